// File: rtl/signal_color_pipe.sv
// signal_color_pipe: pipelined pixel colour mapper (input register, S1 t, S2 argmax, S3 blend).
// Define CURSOR_BLINK_EN to blink the view/write location markers on a frame counter.
module signal_color_pipe #(
   parameter int unsigned         SIG_W    = 10,
   parameter int unsigned         N_CH     = 2,
   parameter int unsigned         DISP_MIN = 8,
   parameter int unsigned         T_SHIFT  = 1,
   parameter logic [24*N_CH-1:0]  TINT_RGB = {24'hFF3300, 24'h66FFFF},
   parameter int unsigned         BLINK_FR = 16
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    in_valid,
   input  logic                    in_hs,
   input  logic                    in_vs,
   input  logic                    frame_start,
   input  logic                    renderAnt,
   input  logic                    renderSugar,
   input  logic                    renderNest,
   input  logic                    render_viewLoc,
   input  logic                    render_writeLoc,
   input  logic [SIG_W*N_CH-1:0]   renderSignal,
   output logic                    out_valid,
   output logic                    out_hs,
   output logic                    out_vs,
   output logic [7:0]              VGA_R,
   output logic [7:0]              VGA_G,
   output logic [7:0]              VGA_B
);

   localparam int unsigned D_W = SIG_W + 1;
   localparam int unsigned C_W = 2;
   localparam int unsigned F_W = 5;

   localparam int unsigned F_VIEW  = 0;
   localparam int unsigned F_WRITE = 1;
   localparam int unsigned F_ANT   = 2;
   localparam int unsigned F_SUGAR = 3;
   localparam int unsigned F_NEST  = 4;

   localparam logic [23:0] GRASS_RGB = 24'h669900;
   localparam logic [23:0] VIEW_RGB  = 24'hCC2000;
   localparam logic [23:0] WRITE_RGB = 24'hEE6000;
   localparam logic [23:0] ANT_RGB   = 24'h000000;
   localparam logic [23:0] SUGAR_RGB = 24'hFFFFFF;
   localparam logic [23:0] NEST_RGB  = 24'h8B4513;

   logic vis_c;

`ifdef CURSOR_BLINK_EN
   logic [7:0] frame_cnt;
   logic       blink_on;

   // Marker blink: phase toggles every BLINK_FR frames, starting visible.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_cnt <= 8'd0;
         blink_on  <= 1'b1;
      end else if (frame_start) begin
         if (frame_cnt == 8'(BLINK_FR - 1)) begin
            frame_cnt <= 8'd0;
            blink_on  <= ~blink_on;
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   assign vis_c = blink_on;
`else
   logic unused_blink;

   assign vis_c        = 1'b1;
   assign unused_blink = ^{frame_start, BLINK_FR};
`endif

   // Channel intensity: offset above the display floor, scaled and saturated.
   function automatic logic [7:0] calc_t(input logic [SIG_W-1:0] sig);
      logic [D_W-1:0] diff;
      logic [D_W-1:0] sh;
      calc_t = 8'd0;
      diff   = '0;
      sh     = '0;
      if (D_W'(sig) > D_W'(DISP_MIN)) begin
         diff   = D_W'(sig) - D_W'(DISP_MIN);
         sh     = diff >> T_SHIFT;
         calc_t = (sh > D_W'(255)) ? 8'd255 : sh[7:0];
      end
   endfunction

   // One colour component moved from grass toward the tint by t/256, floor rounding.
   function automatic logic [7:0] lerp(input logic [7:0] grass,
                                       input logic [7:0] tint,
                                       input logic [7:0] t);
      logic signed [8:0]  d;
      logic signed [16:0] p;
      logic signed [9:0]  s;
      d = $signed({1'b0, tint}) - $signed({1'b0, grass});
      p = 17'(d) * $signed({9'b0, t});
      s = $signed({2'b00, grass}) + 10'(p >>> 8);
      if (s[9])      lerp = 8'd0;
      else if (s[8]) lerp = 8'd255;
      else           lerp = s[7:0];
   endfunction

   function automatic logic [23:0] tint_of(input logic [C_W-1:0] c);
      tint_of = TINT_RGB[23:0];
      for (int i = 1; i < int'(N_CH); i++) begin
         if (c == C_W'(i)) tint_of = TINT_RGB[24*i +: 24];
      end
   endfunction

   // Input register
   logic                   r0_valid, r0_hs, r0_vs;
   logic [F_W-1:0]         r0_flags;
   logic [SIG_W*N_CH-1:0]  r0_sig;

   // S1 register
   logic                   s1_valid, s1_hs, s1_vs;
   logic [F_W-1:0]         s1_flags;
   logic [N_CH-1:0][7:0]   s1_t;

   // S2 register
   logic                   s2_valid, s2_hs, s2_vs;
   logic [F_W-1:0]         s2_flags;
   logic [C_W-1:0]         s2_c;
   logic [7:0]             s2_t;

   logic [N_CH-1:0][7:0]   t_c;
   logic [C_W-1:0]         dom_c_c;
   logic [7:0]             dom_t_c;
   logic [23:0]            tint_c;
   logic [23:0]            rgb_c;

   always_comb begin
      t_c = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         t_c[i] = calc_t(r0_sig[i*SIG_W +: SIG_W]);
      end
   end

   // Strict compare keeps the lowest index on ties; all-zero gives channel 0.
   always_comb begin
      dom_c_c = '0;
      dom_t_c = s1_t[0];
      for (int i = 1; i < int'(N_CH); i++) begin
         if (s1_t[i] > dom_t_c) begin
            dom_t_c = s1_t[i];
            dom_c_c = C_W'(i);
         end
      end
   end

   always_comb begin
      tint_c = tint_of(s2_c);
      rgb_c  = {lerp(GRASS_RGB[23:16], tint_c[23:16], s2_t),
                lerp(GRASS_RGB[15:8],  tint_c[15:8],  s2_t),
                lerp(GRASS_RGB[7:0],   tint_c[7:0],   s2_t)};
      if (s2_flags[F_VIEW])       rgb_c = VIEW_RGB;
      else if (s2_flags[F_WRITE]) rgb_c = WRITE_RGB;
      else if (s2_flags[F_ANT])   rgb_c = ANT_RGB;
      else if (s2_flags[F_SUGAR]) rgb_c = SUGAR_RGB;
      else if (s2_flags[F_NEST])  rgb_c = NEST_RGB;
      if (!s2_valid) rgb_c = 24'h000000;
   end

   // Marker flags are gated by visibility on entry so each pixel keeps its own phase.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r0_valid  <= 1'b0;
         r0_hs     <= 1'b0;
         r0_vs     <= 1'b0;
         r0_flags  <= '0;
         r0_sig    <= '0;
         s1_valid  <= 1'b0;
         s1_hs     <= 1'b0;
         s1_vs     <= 1'b0;
         s1_flags  <= '0;
         s1_t      <= '0;
         s2_valid  <= 1'b0;
         s2_hs     <= 1'b0;
         s2_vs     <= 1'b0;
         s2_flags  <= '0;
         s2_c      <= '0;
         s2_t      <= 8'd0;
         out_valid <= 1'b0;
         out_hs    <= 1'b0;
         out_vs    <= 1'b0;
         VGA_R     <= 8'd0;
         VGA_G     <= 8'd0;
         VGA_B     <= 8'd0;
      end else begin
         r0_valid  <= in_valid;
         r0_hs     <= in_hs;
         r0_vs     <= in_vs;
         r0_flags  <= {renderNest, renderSugar, renderAnt,
                       render_writeLoc & vis_c, render_viewLoc & vis_c};
         r0_sig    <= renderSignal;

         s1_valid  <= r0_valid;
         s1_hs     <= r0_hs;
         s1_vs     <= r0_vs;
         s1_flags  <= r0_flags;
         s1_t      <= t_c;

         s2_valid  <= s1_valid;
         s2_hs     <= s1_hs;
         s2_vs     <= s1_vs;
         s2_flags  <= s1_flags;
         s2_c      <= dom_c_c;
         s2_t      <= dom_t_c;

         out_valid <= s2_valid;
         out_hs    <= s2_hs;
         out_vs    <= s2_vs;
         VGA_R     <= rgb_c[23:16];
         VGA_G     <= rgb_c[15:8];
         VGA_B     <= rgb_c[7:0];
      end
   end

endmodule

// File: tb/tb_signal_color_pipe.sv
// tb_signal_color_pipe: scoreboard bench for signal_color_pipe with directed, hand-computed vectors.
// Blink expectations follow CURSOR_BLINK_EN when it is defined for the build.
module tb_signal_color_pipe;

   localparam int unsigned SIG_W = 10;
   localparam int unsigned N_CH  = 2;

`ifdef CURSOR_BLINK_EN
   localparam bit BLINK_BUILD = 1'b1;
`else
   localparam bit BLINK_BUILD = 1'b0;
`endif

   localparam logic [4:0] FV = 5'b00001;
   localparam logic [4:0] FW = 5'b00010;
   localparam logic [4:0] FA = 5'b00100;
   localparam logic [4:0] FS = 5'b01000;
   localparam logic [4:0] FN = 5'b10000;

   logic                   Clk = 1'b0;
   logic                   Reset;
   logic                   in_valid, in_hs, in_vs, frame_start;
   logic                   renderAnt, renderSugar, renderNest, render_viewLoc, render_writeLoc;
   logic [SIG_W*N_CH-1:0]  renderSignal;
   logic                   out_valid, out_hs, out_vs;
   logic [7:0]             VGA_R, VGA_G, VGA_B;

   typedef struct {
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
      int          edge_no;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   signal_color_pipe #(.BLINK_FR(2)) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .in_valid        (in_valid),
      .in_hs           (in_hs),
      .in_vs           (in_vs),
      .frame_start     (frame_start),
      .renderAnt       (renderAnt),
      .renderSugar     (renderSugar),
      .renderNest      (renderNest),
      .render_viewLoc  (render_viewLoc),
      .render_writeLoc (render_writeLoc),
      .renderSignal    (renderSignal),
      .out_valid       (out_valid),
      .out_hs          (out_hs),
      .out_vs          (out_vs),
      .VGA_R           (VGA_R),
      .VGA_G           (VGA_G),
      .VGA_B           (VGA_B)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit marker_on(input int fr);
      return !BLINK_BUILD || ((fr % 4) < 2);
   endfunction

   // One pixel per call, driven on the falling edge; valid pixels are queued with the sampling edge.
   task automatic drive(input logic v, input logic [4:0] fl, input logic [9:0] c0,
                        input logic [9:0] c1, input logic hs, input logic vs,
                        input logic fs, input logic [23:0] exp_rgb);
      exp_t e;
      @(negedge Clk);
      in_valid     = v;
      in_hs        = hs;
      in_vs        = vs;
      frame_start  = fs;
      {renderNest, renderSugar, renderAnt, render_writeLoc, render_viewLoc} = fl;
      renderSignal = {c1, c0};
      if (v && !Reset) begin
         e.rgb     = exp_rgb;
         e.hs      = hs;
         e.vs      = vs;
         e.edge_no = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 24'h0);
   endtask

   // Monitor: pops an expectation for every valid output and checks colour, syncs and latency.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clk);
         #1;
         if (mon_en) begin
            if (out_valid === 1'b1) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out: out_valid=1 with nothing expected (edge %0d)", cyc);
               end else begin
                  e = sb.pop_front();
                  check("rgb",     32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
                  check("out_hs",  32'(out_hs), 32'(e.hs));
                  check("out_vs",  32'(out_vs), 32'(e.vs));
                  check("latency", 32'(cyc - e.edge_no), 32'd3);
               end
            end else begin
               check("idle_rgb", 32'({out_valid, VGA_R, VGA_G, VGA_B}), 32'd0);
            end
         end
      end
   end

   initial begin : stim
      Reset = 1'b1;
      in_valid = 1'b0; in_hs = 1'b0; in_vs = 1'b0; frame_start = 1'b0;
      renderAnt = 1'b0; renderSugar = 1'b0; renderNest = 1'b0;
      render_viewLoc = 1'b0; render_writeLoc = 1'b0;
      renderSignal = '0;

      repeat (3) @(posedge Clk);
      #1;
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      check("reset_hs",    32'(out_hs), 32'd0);
      check("reset_vs",    32'(out_vs), 32'd0);
      @(negedge Clk);
      Reset  = 1'b0;
      mon_en = 1'b1;

      // Back-to-back stream: threshold, saturation, ties, dominance, signed blend, overrides
      drive(1, 5'd0,    10'd8,    10'd0,    0, 0, 0, 24'h669900);
      drive(1, 5'd0,    10'd9,    10'd0,    0, 0, 0, 24'h669900);
      drive(1, 5'd0,    10'd10,   10'd0,    0, 0, 0, 24'h669900);
      drive(1, 5'd0,    10'd520,  10'd0,    0, 0, 0, 24'h66FEFE);
      drive(1, 5'd0,    10'd521,  10'd0,    0, 0, 0, 24'h66FEFE);
      drive(1, 5'd0,    10'd1023, 10'd0,    0, 0, 0, 24'h66FEFE);
      drive(1, 5'd0,    10'd264,  10'd0,    0, 0, 0, 24'h66CC7F);
      drive(1, 5'd0,    10'd300,  10'd300,  0, 0, 0, 24'h66D391);
      drive(1, 5'd0,    10'd1023, 10'd1023, 0, 0, 0, 24'h66FEFE);
      drive(1, 5'd0,    10'd100,  10'd520,  1, 0, 0, 24'hFE3300);
      drive(1, 5'd0,    10'd100,  10'd520,  0, 1, 0, 24'hFE3300);
      drive(1, 5'd0,    10'd100,  10'd520,  1, 1, 0, 24'hFE3300);
      drive(1, 5'd0,    10'd0,    10'd266,  0, 0, 0, 24'hB36500);
      drive(1, FA|FS|FN, 10'd520, 10'd0,    0, 0, 0, 24'h000000);
      drive(1, FV|FA,   10'd0,    10'd0,    0, 0, 0, 24'hCC2000);
      drive(1, FW,      10'd0,    10'd0,    1, 0, 0, 24'hEE6000);
      drive(1, FS|FN,   10'd0,    10'd0,    0, 0, 0, 24'hFFFFFF);
      drive(1, FN,      10'd300,  10'd0,    0, 1, 0, 24'h8B4513);
      drive(1, FV|FW,   10'd0,    10'd0,    0, 0, 0, 24'hCC2000);

      // Invalid pixels with flags and syncs must produce black, unqueued outputs
      drive(0, FS,      10'd520,  10'd0,    1, 1, 0, 24'h0);
      drive(0, FV,      10'd0,    10'd520,  1, 0, 0, 24'h0);
      drive(1, 5'd0,    10'd8,    10'd0,    0, 0, 0, 24'h669900);
      repeat (5) idle();

      // Mid-stream reset flushes everything in flight
      for (int i = 0; i < 5; i++) drive(1, 5'd0, 10'd520, 10'd0, 1'(i), 0, 0, 24'h66FEFE);
      @(negedge Clk);
      Reset = 1'b1;
      sb.delete();
      @(posedge Clk);
      #1;
      check("reset_flush_valid", 32'(out_valid), 32'd0);
      check("reset_flush_rgb",   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      @(negedge Clk);
      Reset    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) drive(1, 5'd0, 10'd100, 10'd520, 1'(i / 2), 0, 0, 24'hFE3300);
         else            drive(1, 5'd0, 10'd264, 10'd0,   0, 1'(i / 2), 0, 24'h66CC7F);
      end
      repeat (5) idle();

      // Marker blink across frames with viewLoc held over a blend of 66,CC,7F
      @(negedge Clk);
      Reset = 1'b1;
      sb.delete();
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Reset    = 1'b0;
      in_valid = 1'b0;
      for (int fr = 0; fr < 6; fr++) begin
         if (fr > 0) drive(0, FV, 10'd264, 10'd0, 0, 0, 1, 24'h0);
         repeat (7) drive(1, FV, 10'd264, 10'd0, 0, 0, 0,
                          marker_on(fr) ? 24'hCC2000 : 24'h66CC7F);
      end
      idle();

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge Clk);
      repeat (2) @(posedge Clk);
      #2;
      check("drain_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
